pe_context_sequencer: RTL
=========================

// Module: pe_context_sequencer
// PURPOSE
//  Controller for the per-PE context cache. It streams configuration words into the cache
//  during LOAD, then steps the context pointer CP through the loaded contexts during RUN,
//  optionally looping a programmed number of iterations. It sits between the array config
//  bus and each PE's context cache. It owns the cache's start and indata pins.
// PARAMETERS
//  WIDTH  120  MSB index of a context word (word is WIDTH+1 bits)
//  DEPTH  64   number of cache entries; max contexts loadable
//  CPW    16   width of CP and of the count and iteration fields
// PORTS
//  CLK           in   1        clock, rising edge
//  RST           in   1        asynchronous reset, active-high
//  load_req      in   1        IDLE: begin LOAD
//  cfg_valid     in   1        config word valid
//  cfg_ready     out  1        sequencer accepts config word
//  cfg_data      in   WIDTH+1  config word
//  cfg_last      in   1        last word of program (qualified by accept)
//  run_go        in   1        IDLE: begin RUN
//  iter_count    in   CPW      loop iterations, sampled on run_go; 0 is treated as 1
//  stall         in   1        RUN: hold CP
//  abort         in   1        LOAD/RUN: return to IDLE
//  cache_indata  out  WIDTH+1  to cache indata (combinational = cfg_data)
//  cache_start   out  1        to cache start; 0 only on an accepted write cycle
//  CP            out  CPW      to cache CP; current context index
//  ctx_valid     out  1        RUN and not stall: CP is executing this cycle
//  loaded_count  out  CPW      number of words written into cache
//  busy          out  1        state is LOAD or RUN
//  done          out  1        one-cycle pulse at end of RUN
// BEHAVIOUR
//  - Reset values: state=IDLE, CP=0, loaded_count=0, done=0, busy=0, ctx_valid=0, cfg_ready=0,
//    cache_start=1.
//  - The cache writes on every CLK edge with start=0. Therefore:
//    cache_start = ~(state==LOAD & cfg_valid & cfg_ready) (combinational).
//  - States: IDLE, LOAD, RUN, DONE.
//  - IDLE
//    - load_req with loaded_count==0 -> LOAD.
//    - load_req with loaded_count!=0 is ignored. The cache write pointer has no reset, so
//      RST and a cache re-init always happen together.
//    - run_go with loaded_count>0 -> RUN; CP=0, iter=0, iter_count latched.
//    - load_req and run_go together: load_req wins.
//  - LOAD
//    - cfg_ready=1 while loaded_count<DEPTH.
//    - On accept: loaded_count+1.
//    - Accept with cfg_last, or accept that makes loaded_count==DEPTH -> IDLE next cycle.
//    - cfg_valid low: no write and no count change.
//  - RUN
//    - ctx_valid=~stall. With stall=1, CP holds.
//    - With stall=0: if CP<loaded_count-1, CP+1. Otherwise CP wraps to 0 and iter+1.
//    - When iter was max(iter_count,1)-1 -> DONE instead of wrapping.
//    - Latency: first context appears on CP the cycle after run_go.
//  - DONE: done=1 for exactly one cycle, CP=0, then IDLE.
//  - abort in LOAD or RUN -> IDLE next cycle, CP=0, no done.
//    - Words already accepted stay counted.
//    - abort wins over a simultaneous accept: cfg_ready is forced 0 that cycle.
//  - RST mid-operation returns to the reset values immediately.
//  - CP increments never exceed loaded_count-1; loaded_count never exceeds DEPTH.
// CONFIGURATION
//  PE_CTX_SEQ_PERF_EN
//    - Defined: adds outputs perf_run_cycles[31:0] and perf_stall_cycles[31:0].
//      - Both clear on run_go.
//      - They count RUN cycles and RUN&stall cycles respectively, saturating at all-ones.
//      - Both reset to 0.
//    - Undefined: these ports and counters are absent; all other behaviour is identical.
// TESTING
//  - Reset checks:
//    - RST pulse -> cache_start=1, CP=0, done=0, busy=0, cfg_ready=0.
//    - Async: observed before the next CLK edge.
//  - Load with gaps:
//    - load_req, then 3 words with cfg_valid gaps, third with cfg_last -> exactly 3 cycles
//      with cache_start=0.
//    - loaded_count=3, then IDLE.
//  - Load overflow:
//    - 70 words, no cfg_last -> 64 accepts.
//    - cfg_ready=0 after the 64th; loaded_count=64; back to IDLE.
//  - Looped run:
//    - loaded_count=3, iter_count=2, no stall -> CP = 0,1,2,0,1,2.
//    - Then a done pulse, 7 cycles after run_go; then IDLE.
//  - Stall and iter_count=0:
//    - Stall asserted 2 cycles at CP=1 -> CP holds 1 and ctx_valid=0 for those cycles.
//    - iter_count=0 runs one pass.
//  - Abort and request rules:
//    - abort during RUN at CP=2 -> IDLE, CP=0, no done.
//    - load_req with loaded_count!=0 is ignored.
//    - load_req+run_go together -> LOAD.

Source files
------------

// File: rtl/pe_context_sequencer.sv
// Context-cache sequencer: streams config words into a PE context cache (LOAD),
// then steps CP through the loaded contexts with optional looping (RUN).
// Optional performance counters are built when PE_CTX_SEQ_PERF_EN is defined.
module pe_context_sequencer #(
    parameter int WIDTH = 120,
    parameter int DEPTH = 64,
    parameter int CPW   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_req,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH:0]   cfg_data,
    input  logic             cfg_last,
    input  logic             run_go,
    input  logic [CPW-1:0]   iter_count,
    input  logic             stall,
    input  logic             abort,
    output logic [WIDTH:0]   cache_indata,
    output logic             cache_start,
    output logic [CPW-1:0]   CP,
    output logic             ctx_valid,
    output logic [CPW-1:0]   loaded_count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
`ifdef PE_CTX_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_run_cycles,
    output logic [31:0]      perf_stall_cycles
`endif
);

    // Config handshake: a word transfers on a rising CLK edge where cfg_valid
    // and cfg_ready are both high; that same edge is the cache write (start=0).
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [CPW-1:0] DEPTH_C = CPW'(DEPTH);
    localparam logic [CPW-1:0] ONE_C   = CPW'(1);

    state_t         state, state_nx;
    logic [CPW-1:0] iter, iter_lim;
    logic           accept, load_start, run_start, cp_last, iter_last;

    assign accept     = (state == S_LOAD) && cfg_valid && cfg_ready;
    assign load_start = (state == S_IDLE) && load_req && (loaded_count == '0);
    assign run_start  = (state == S_IDLE) && run_go && !load_start && (loaded_count != '0);
    assign cp_last    = (CP >= loaded_count - ONE_C);
    assign iter_last  = (iter == iter_lim - ONE_C);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (load_start)     state_nx = S_LOAD;
                else if (run_start) state_nx = S_RUN;
            end
            S_LOAD: begin
                if (abort) state_nx = S_IDLE;
                else if (accept && (cfg_last || loaded_count == DEPTH_C - ONE_C))
                    state_nx = S_IDLE;
            end
            S_RUN: begin
                if (abort) state_nx = S_IDLE;
                else if (!stall && cp_last && iter_last) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready    = (state == S_LOAD) && (loaded_count < DEPTH_C) && !abort;
        cache_start  = !accept;
        cache_indata = cfg_data;
        ctx_valid    = (state == S_RUN) && !stall;
        busy         = (state == S_LOAD) || (state == S_RUN);
        done         = (state == S_DONE);
        state_dbg    = state;
    end

    // CP is zero everywhere except while RUN is advancing through contexts.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CP           <= '0;
            loaded_count <= '0;
            iter         <= '0;
            iter_lim     <= ONE_C;
        end else begin
            if (accept) loaded_count <= loaded_count + ONE_C;
            if (run_start) begin
                iter     <= '0;
                iter_lim <= (iter_count == '0) ? ONE_C : iter_count;
            end
            if (state == S_RUN && !abort) begin
                if (!stall) begin
                    if (cp_last) begin
                        CP   <= '0;
                        iter <= iter + ONE_C;
                    end else begin
                        CP <= CP + ONE_C;
                    end
                end
            end else begin
                CP <= '0;
            end
        end
    end

`ifdef PE_CTX_SEQ_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_run_cycles   <= '0;
            perf_stall_cycles <= '0;
        end else if (run_start) begin
            perf_run_cycles   <= '0;
            perf_stall_cycles <= '0;
        end else if (state == S_RUN) begin
            if (perf_run_cycles != '1) perf_run_cycles <= perf_run_cycles + 32'd1;
            if (stall && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
